// File: rtl/hdmi_video_timing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : hdmi_pkg                                                      |
// | Description: Shared constants for the HDMI raster timing generator:        |
// |              640x480@60 mode numbers, axis-total helper, TMDS control      |
// |              tokens and the colour-bar test pattern table.                 |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package hdmi_pkg;

  typedef logic [23:0] rgb_t;

  // Sum of the four regions of one axis (active, front porch, sync, back porch)
  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // 640x480@60, 25.175 MHz pixel clock
  localparam int c_H_ACTIVE_640 = 640;
  localparam int c_H_FP_640     = 16;
  localparam int c_H_SYNC_640   = 96;
  localparam int c_H_BP_640     = 48;
  localparam int c_V_ACTIVE_480 = 480;
  localparam int c_V_FP_480     = 10;
  localparam int c_V_SYNC_480   = 2;
  localparam int c_V_BP_480     = 33;
  localparam int c_H_TOTAL_640  = axis_total(c_H_ACTIVE_640, c_H_FP_640, c_H_SYNC_640, c_H_BP_640);
  localparam int c_V_TOTAL_480  = axis_total(c_V_ACTIVE_480, c_V_FP_480, c_V_SYNC_480, c_V_BP_480);

  // TMDS control tokens sent on a channel during blanking, indexed by {C1,C0}
  localparam logic [9:0] c_TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] c_TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] c_TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] c_TMDS_CTRL_11 = 10'b1010101011;

  // Eight vertical bars, left to right
  localparam int c_NUM_BARS = 8;

  function automatic rgb_t colour_bar(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;  // white
      3'd1:    c = 24'hFFFF00;  // yellow
      3'd2:    c = 24'h00FFFF;  // cyan
      3'd3:    c = 24'h00FF00;  // green
      3'd4:    c = 24'hFF00FF;  // magenta
      3'd5:    c = 24'hFF0000;  // red
      3'd6:    c = 24'h0000FF;  // blue
      default: c = 24'h000000;  // black
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hdmi_video_timing_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface  : hdmi_video_timing_if                                          |
// | Description: Pixel-advance strobe in, raster timing and coordinates out.   |
// |              rgb exists only when VIDEO_TIMING_TESTPAT_EN is defined.      |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface hdmi_video_timing_if #(
  parameter int CW = 12
) ();
  logic          ce;
  logic          de;
  logic          hsync;
  logic          vsync;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          frame_start;
  logic          line_start;
`ifdef VIDEO_TIMING_TESTPAT_EN
  logic [23:0]   rgb;
`endif

  modport master (
    input  ce,
    output de, hsync, vsync, x, y, frame_start, line_start
`ifdef VIDEO_TIMING_TESTPAT_EN
    , output rgb
`endif
  );

  modport slave (
    output ce,
    input  de, hsync, vsync, x, y, frame_start, line_start
`ifdef VIDEO_TIMING_TESTPAT_EN
    , input rgb
`endif
  );
endinterface
`default_nettype wire

// File: rtl/hdmi_video_timing_axis_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : vt_axis_counter                                               |
// | Description: One raster axis: position counter plus combinational decode   |
// |              of active region, sync region (with polarity) and wrap.       |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module vt_axis_counter
  import hdmi_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter bit POL    = 1'b0,
  parameter int CW     = 12
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          ce,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          active,
  output logic          sync,
  output logic          wrap
);
  localparam int            c_TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CW-1:0] c_LAST       = CW'(c_TOTAL - 1);
  localparam logic [CW-1:0] c_ACT_END    = CW'(ACTIVE);
  localparam logic [CW-1:0] c_SYNC_BEGIN = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] c_SYNC_END   = CW'(ACTIVE + FP + SYNC);

  logic [CW-1:0] r_cnt;
  logic          w_in_sync;

  assign cnt       = r_cnt;
  assign wrap      = inc && (r_cnt == c_LAST);
  assign active    = (r_cnt < c_ACT_END);
  assign w_in_sync = (r_cnt >= c_SYNC_BEGIN) && (r_cnt < c_SYNC_END);
  assign sync      = w_in_sync ? POL : ~POL;

  // Advance one position per enabled step, wrapping after the back porch
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (ce && inc) begin
      r_cnt <= wrap ? '0 : r_cnt + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/hdmi_video_timing.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : hdmi_video_timing                                             |
// | Description: Raster timing generator for the TMDS encoders. Registers DE,  |
// |              HSYNC, VSYNC, pixel coordinates and start pulses, all aligned.|
// |              Optional colour-bar pattern: VIDEO_TIMING_TESTPAT_EN.         |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module hdmi_video_timing
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE = c_H_ACTIVE_640,
  parameter int H_FP     = c_H_FP_640,
  parameter int H_SYNC   = c_H_SYNC_640,
  parameter int H_BP     = c_H_BP_640,
  parameter int V_ACTIVE = c_V_ACTIVE_480,
  parameter int V_FP     = c_V_FP_480,
  parameter int V_SYNC   = c_V_SYNC_480,
  parameter int V_BP     = c_V_BP_480,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 12
) (
  input  logic                clk,
  input  logic                resetn,
  hdmi_video_timing_if.master vid
);
  logic [CW-1:0] w_h_cnt;
  logic [CW-1:0] w_v_cnt;
  logic          w_h_act;
  logic          w_v_act;
  logic          w_h_sync;
  logic          w_v_sync;
  logic          w_h_wrap;
  logic          w_unused_v_wrap;
  logic          w_de_next;

  logic          r_de;
  logic          r_hsync;
  logic          r_vsync;
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          r_frame_start;
  logic          r_line_start;

  vt_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .CW(CW)
  ) u_h_axis (
    .clk(clk), .resetn(resetn), .ce(vid.ce), .inc(1'b1),
    .cnt(w_h_cnt), .active(w_h_act), .sync(w_h_sync), .wrap(w_h_wrap)
  );

  // Vertical axis steps once per completed line
  vt_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .CW(CW)
  ) u_v_axis (
    .clk(clk), .resetn(resetn), .ce(vid.ce), .inc(w_h_wrap),
    .cnt(w_v_cnt), .active(w_v_act), .sync(w_v_sync), .wrap(w_unused_v_wrap)
  );

  assign w_de_next = w_h_act && w_v_act;

  // Register the decode of the position being emitted on this step; x/y freeze in blanking
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_de          <= 1'b0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_x           <= '0;
      r_y           <= '0;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
    end else if (vid.ce) begin
      r_de          <= w_de_next;
      r_hsync       <= w_h_sync;
      r_vsync       <= w_v_sync;
      r_line_start  <= (w_h_cnt == '0);
      r_frame_start <= (w_h_cnt == '0) && (w_v_cnt == '0);
      if (w_de_next) begin
        r_x <= w_h_cnt;
        r_y <= w_v_cnt;
      end
    end
  end

  assign vid.de          = r_de;
  assign vid.hsync       = r_hsync;
  assign vid.vsync       = r_vsync;
  assign vid.x           = r_x;
  assign vid.y           = r_y;
  assign vid.frame_start = r_frame_start;
  assign vid.line_start  = r_line_start;

`ifdef VIDEO_TIMING_TESTPAT_EN
  localparam logic [CW-1:0] c_BAR_W = CW'(H_ACTIVE / c_NUM_BARS);

  rgb_t r_rgb;

  // Colour bar for the emitted pixel, black outside active video
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rgb <= '0;
    end else if (vid.ce) begin
      r_rgb <= w_de_next ? colour_bar(3'(w_h_cnt / c_BAR_W)) : '0;
    end
  end

  assign vid.rgb = r_rgb;
`endif
endmodule
`default_nettype wire
